// File: rtl/uart_dec_frame_display.sv
// uart_dec_frame_display
// Builds a NUM_DIGITS-digit BCD value from an ASCII byte stream coming from uart_rx.
// Framing is either a fixed digit count (MODE 0) or a line ended by CR/LF (MODE 1).
// An optional inter-byte timeout drops a partial frame. The committed value is also
// time-multiplexed onto one shared 7-seg decoder through scan_sel, scan_bcd and scan_blank.
module uart_dec_frame_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int MODE           = 0,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int BLANK_LEADING  = 0,
  parameter int SCAN_DIV       = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_valid,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic                    busy,
  output logic [NUM_DIGITS-1:0]   scan_sel,
  output logic [3:0]              scan_bcd,
  output logic                    scan_blank
);

  localparam int BW    = 4 * NUM_DIGITS;
  localparam int CW    = $clog2(NUM_DIGITS + 1);
  localparam int TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TLAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW    = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   shadow_q, shadow_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            busy_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [DW-1:0]   div_q, div_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic            is_digit, is_term, is_esc;
  logic [3:0]      digit_val;
  logic [BW-1:0]   shadow_shift;
  logic [NUM_DIGITS-1:0] blank_commit;

  assign is_digit     = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
  assign is_term      = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
  assign is_esc       = (rx_byte == 8'h1B);
  assign digit_val    = 4'(rx_byte - 8'h30);
  // newest digit enters at the ones position, older digits move up one place
  assign shadow_shift = (shadow_q << 4) | BW'(digit_val);

  // positions above the received digit count are blanked in line mode when enabled
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      assign blank_commit[gi] = (BLANK_LEADING != 0) && (MODE != 0) && (CW'(gi) >= count_q);
    end
  endgenerate

  // framing FSM next-state: byte classification, commit/error decisions, timeout
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    bcd_d    = bcd_q;
    blank_d  = blank_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    timer_d  = '0;
    if (rx_valid) begin
      if (is_esc) begin
        state_d  = IDLE;
        count_d  = '0;
        shadow_d = '0;
      end else if (is_digit) begin
        if (state_q != DISCARD) begin
          if (MODE == 0) begin
            if (count_q == CW'(NUM_DIGITS - 1)) begin
              bcd_d    = shadow_shift;
              blank_d  = '0;
              done_d   = 1'b1;
              state_d  = IDLE;
              count_d  = '0;
              shadow_d = '0;
            end else begin
              shadow_d = shadow_shift;
              count_d  = count_q + CW'(1);
              state_d  = COLLECT;
            end
          end else begin
            if (count_q == CW'(NUM_DIGITS)) begin
              err_d    = 1'b1;
              state_d  = DISCARD;
              count_d  = '0;
              shadow_d = '0;
            end else begin
              shadow_d = shadow_shift;
              count_d  = count_q + CW'(1);
              state_d  = COLLECT;
            end
          end
        end
      end else if (is_term) begin
        // a terminator in IDLE is dropped so CRLF gives a single commit
        if (MODE != 0) begin
          if (state_q == COLLECT) begin
            bcd_d    = shadow_q;
            blank_d  = blank_commit;
            done_d   = 1'b1;
            state_d  = IDLE;
            count_d  = '0;
            shadow_d = '0;
          end else if (state_q == DISCARD) begin
            state_d = IDLE;
          end
        end
      end else begin
        if ((MODE != 0) && (state_q != DISCARD)) begin
          err_d    = 1'b1;
          state_d  = DISCARD;
          count_d  = '0;
          shadow_d = '0;
        end
      end
    end else if ((TIMEOUT_CYCLES > 0) && (state_q != IDLE)) begin
      if (timer_q == TW'(TLAST)) begin
        err_d    = 1'b1;
        state_d  = IDLE;
        count_d  = '0;
        shadow_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  // free-running scan divider and digit index
  always_comb begin
    if (div_q == DW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      div_d = div_q + DW'(1);
      idx_d = idx_q;
    end
  end

  // state, committed value and scan registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      shadow_q <= '0;
      bcd_q    <= '0;
      blank_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      timer_q  <= '0;
      div_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      bcd_q    <= bcd_d;
      blank_q  <= blank_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= (state_d != IDLE);
      timer_q  <= timer_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
    end
  end

  // shared-decoder digit select from the registered committed value
  always_comb begin
    scan_bcd   = 4'h0;
    scan_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        scan_bcd   = bcd_q[4*i +: 4];
        scan_blank = blank_q[i];
      end
    end
  end

  assign scan_sel   = NUM_DIGITS'(1) << idx_q;
  assign bcd_out    = bcd_q;
  assign blank_mask = blank_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule

// File: doc/uart_dec_frame_display.md
Name: uart_dec_frame_display

Overview:
Parametrised successor to the two-digit ASCII-to-BCD capture logic. It sits between uart_rx (rx_byte/rx_done) and bcd_to_seg. It assembles NUM_DIGITS decimal digits from the ASCII byte stream, in either fixed-length or terminator-delimited framing, with inter-byte timeout, error reporting and leading-digit blanking. It also time-multiplexes the committed value onto a single shared 7-seg decoder.

Parameters:
NUM_DIGITS, 4, digit count (1..8); digit 0 is least significant.
MODE, 0, 0 = fixed frame of exactly NUM_DIGITS digits; 1 = variable-length frame closed by CR (0x0D) or LF (0x0A).
TIMEOUT_CYCLES, 0, inter-byte gap that aborts a partial frame; 0 disables the timeout.
BLANK_LEADING, 0, MODE 1 only: 1 = unreceived high positions are blanked, 0 = shown as zero.
SCAN_DIV, 1024, clk cycles per display scan slot (>= 2).

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous, active-high reset.
rx_byte  in  8  received byte; valid only while rx_valid = 1.
rx_valid  in  1  one-cycle strobe (uart_rx rx_done).
bcd_out  out  4*NUM_DIGITS  committed value; digit i occupies [4i+3:4i].
blank_mask  out  NUM_DIGITS  bit i = 1 means digit i is blank.
frame_done  out  1  one-cycle pulse when bcd_out/blank_mask update.
frame_err  out  1  one-cycle pulse when a frame is rejected.
busy  out  1  1 while a partial frame is held (state != IDLE).
scan_sel  out  NUM_DIGITS  one-hot active digit select.
scan_bcd  out  4  bcd_out digit at the current scan index.
scan_blank  out  1  blank_mask bit at the current scan index.

Behaviour:
- Reset values (rst synchronous, high): bcd_out 0, blank_mask 0, frame_done 0, frame_err 0, busy 0, scan index 0, scan_sel = 1, divider 0. The shadow register, count and timer are cleared; state = IDLE. A reset mid-frame discards the partial frame with no pulse.
- Byte classes: DIGIT '0'..'9' (value = byte - 0x30); TERM 0x0D/0x0A; ESC 0x1B; OTHER = everything else.
- States: IDLE (count = 0), COLLECT (1 <= count <= NUM_DIGITS), DISCARD (MODE 1 only).
- DIGIT in IDLE/COLLECT: shadow <= {shadow[low digits], value} (shift-left; newest digit is the ones digit); count++.
- MODE 0:
  - When the NUM_DIGITS-th digit arrives, commit on the next edge: bcd_out <= shadow with the new digit; blank_mask <= 0; frame_done = 1 in the cycle after the rx_valid cycle (latency 1). Then count <= 0 and state goes to IDLE.
  - OTHER and TERM are ignored, with no effect on the partial frame.
- MODE 1:
  - TERM in COLLECT commits. Digits received right-justify into the low positions; unreceived positions are 0. Blank_mask bit i = BLANK_LEADING && (i >= count). frame_done pulses at latency 1; state goes to IDLE.
  - TERM in IDLE is ignored silently, so CRLF yields one commit.
  - A DIGIT when count = NUM_DIGITS (overflow) or OTHER in IDLE/COLLECT: frame_err pulses at latency 1 and the state goes to DISCARD.
  - DISCARD ignores every byte except TERM (go to IDLE, no commit, no pulse) and ESC.
- ESC in any state: go to IDLE, clear count and shadow, no pulse, bcd_out unchanged.
- Timeout (TIMEOUT_CYCLES > 0):
  - The timer is cleared on every rx_valid and counts while state != IDLE.
  - Reaching TIMEOUT_CYCLES: frame_err pulse; go to IDLE; partial frame dropped; bcd_out unchanged.
  - rx_valid in the expiry cycle wins: the byte is processed normally, the timer restarts and there is no error.
- bcd_out/blank_mask change only on commit or reset. frame_done and frame_err never assert in the same cycle.
- busy = (state != IDLE), registered.
- Scan:
  - The divider counts 0..SCAN_DIV-1 and runs independently of framing.
  - On wrap, the scan index advances and wraps from NUM_DIGITS-1 to 0.
  - scan_sel = 1 << index. scan_bcd/scan_blank are a combinational select from the registered bcd_out/blank_mask at the index, so they change in the same cycle as a commit.
- Width rules: count is clog2(NUM_DIGITS+1) bits; the timer is sized to TIMEOUT_CYCLES; no arithmetic beyond the subtraction of 0x30 and the counters.

Test Plan:
1. MODE 0, N = 4: send "1234". Required: frame_done one cycle after the '4' strobe; bcd_out = 0x1234; blank_mask = 0; busy 1 from after '1' until the commit.
2. MODE 0: send "12x34", with 'x' mid-frame. Required: 'x' ignored; bcd_out = 0x1234. Then send "56", then ESC, then "7890". Required: bcd_out = 0x7890; no frame_err.
3. MODE 1, N = 4, BLANK_LEADING = 1: send "42\r\n". Required: exactly one frame_done; bcd_out = 0x0042; blank_mask = 4'b1100. Send "12345\n". Required: frame_err after '5'; '\n' exits DISCARD; bcd_out stays 0x0042.
4. MODE 1: send "9a\n". Required: frame_err on 'a', no commit. Send "\n" alone. Required: no pulse.
5. TIMEOUT_CYCLES = 100: send "7", then idle 100 cycles. Required: frame_err, busy drops, bcd_out unchanged. Repeat with the next byte arriving exactly in the expiry cycle. Required: no error, and the frame completes.
6. SCAN_DIV = 4, N = 4, bcd_out = 0x1234: scan_sel cycles 0001→0010→0100→1000→0001 every 4 clocks, with scan_bcd 4,3,2,1. Assert rst mid-frame and mid-scan. Required: all outputs at reset values on the next edge.
